// File: rtl/tti_tx_queue_if.sv
// Bus bundle for the TTI transmit queue: CSR write port, soft-reset handshake,
// controller-side pop port and status flags. Signal suffixes are from the queue's view.
interface tti_tx_queue_if #(
    parameter int DataWidth = 32,
    parameter int ThldWidth = 8
);
    logic                 req_i;
    logic [DataWidth-1:0] data_i;
    logic                 ack_o;
    logic [ThldWidth-1:0] ready_thld_i;
    logic [ThldWidth-1:0] ready_thld_o;
    logic                 reg_rst_i;
    logic                 reg_rst_we_o;
    logic                 reg_rst_data_o;
    logic                 valid_o;
    logic                 ready_i;
    logic [DataWidth-1:0] data_o;
    logic                 full_o;
    logic                 empty_o;
    logic                 thld_o;
    logic                 overflow_o;

    // Driver side: CSR block plus the downstream controller.
    modport master (
        output req_i, data_i, ready_thld_i, reg_rst_i, ready_i,
        input  ack_o, ready_thld_o, reg_rst_we_o, reg_rst_data_o,
        input  valid_o, data_o, full_o, empty_o, thld_o, overflow_o
    );

    // Queue side.
    modport slave (
        input  req_i, data_i, ready_thld_i, reg_rst_i, ready_i,
        output ack_o, ready_thld_o, reg_rst_we_o, reg_rst_data_o,
        output valid_o, data_o, full_o, empty_o, thld_o, overflow_o
    );
endinterface

// File: rtl/tti_tx_queue.sv
// TTI transmit queue: CSR-written FIFO with one-deep pending write, threshold flag
// and soft-reset FSM. Define I3C_TTI_QUEUE_OVERFLOW_EN to build the sticky overflow status.
module tti_tx_queue #(
    parameter int Depth     = 64,
    parameter int DataWidth = 32,
    parameter int ThldWidth = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    tti_tx_queue_if.slave   q
);
    localparam int CW = $clog2(Depth + 1);
    localparam int PW = $clog2(Depth);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        CLEAR = 2'd2,
        WAIT  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 pend_q, pend_d;
    logic [DataWidth-1:0] pend_data_q, pend_data_d;
    logic                 ack_q, ack_d;
    logic [ThldWidth-1:0] ready_thld_q, ready_thld_d;
    logic                 thld_q, thld_d;

    logic                 push;
    logic                 pop;
    logic                 has_space;
    logic [DataWidth-1:0] push_data;
    logic                 is_empty;
    logic                 is_full;
    logic [31:0]          free_w;
    logic [31:0]          eff_thld_w;

    logic [DataWidth-1:0] mem_q [Depth];

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(Depth));

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        ack_d       = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        has_space   = 1'b0;
        push_data   = q.data_i;

        unique case (state_q)
            IDLE: begin
                if (q.reg_rst_i) begin
                    state_d = FLUSH;
                end
                pop       = !is_empty && q.ready_i;
                // A pop in the same cycle frees the slot a full-queue write needs.
                has_space = !is_full || pop;
                if (pend_q) begin
                    if (has_space) begin
                        push      = 1'b1;
                        push_data = pend_data_q;
                        pend_d    = 1'b0;
                        ack_d     = 1'b1;
                    end
                end else if (q.req_i) begin
                    if (has_space) begin
                        push  = 1'b1;
                        ack_d = 1'b1;
                    end else begin
                        pend_d      = 1'b1;
                        pend_data_d = q.data_i;
                    end
                end
                if (push) begin
                    wptr_d = wptr_q + PW'(1);
                end
                if (pop) begin
                    rptr_d = rptr_q + PW'(1);
                end
                count_d = count_q + CW'(push) - CW'(pop);
            end
            FLUSH: begin
                state_d = CLEAR;
                wptr_d  = '0;
                rptr_d  = '0;
                count_d = '0;
                pend_d  = 1'b0;
                // The discarded pending write still gets its acknowledge.
                ack_d   = pend_q || q.req_i;
            end
            CLEAR: begin
                state_d = WAIT;
                ack_d   = q.req_i;
            end
            WAIT: begin
                if (!q.reg_rst_i) begin
                    state_d = IDLE;
                end
                ack_d = q.req_i;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ready_thld_d = q.ready_thld_i;
        if (32'(q.ready_thld_i) > 32'(Depth - 1)) begin
            ready_thld_d = ThldWidth'(Depth - 1);
        end
    end

    assign free_w     = 32'(Depth) - 32'(count_q);
    assign eff_thld_w = (ready_thld_q == '0) ? 32'd1 : 32'(ready_thld_q);
    assign thld_d     = (free_w >= eff_thld_w);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            pend_q       <= 1'b0;
            pend_data_q  <= '0;
            ack_q        <= 1'b0;
            ready_thld_q <= '0;
            thld_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            pend_q       <= pend_d;
            pend_data_q  <= pend_data_d;
            ack_q        <= ack_d;
            ready_thld_q <= ready_thld_d;
            thld_q       <= thld_d;
        end
    end

    // Storage is deliberately left out of reset so it maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

`ifdef I3C_TTI_QUEUE_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (state_q == FLUSH) begin
            overflow_q <= 1'b0;
        end else if (state_q == IDLE && pend_q && q.req_i) begin
            overflow_q <= 1'b1;
        end
    end

    assign q.overflow_o = overflow_q;
`else
    assign q.overflow_o = 1'b0;
`endif

    assign q.ack_o          = ack_q;
    assign q.ready_thld_o   = ready_thld_q;
    assign q.thld_o         = thld_q;
    assign q.reg_rst_we_o   = (state_q == CLEAR);
    assign q.reg_rst_data_o = 1'b0;
    assign q.empty_o        = is_empty;
    assign q.full_o         = is_full;
    assign q.valid_o        = !is_empty;
    assign q.data_o         = is_empty ? '0 : mem_q[rptr_q];

endmodule

// File: tb/tb_tti_tx_queue.sv
// Directed bench for tti_tx_queue: ordering, full/pending write, threshold clamp,
// soft-reset flush and overflow status (both macro settings).
module tb_tti_tx_queue;
    localparam int Depth     = 64;
    localparam int DataWidth = 32;
    localparam int ThldWidth = 8;

`ifdef I3C_TTI_QUEUE_OVERFLOW_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    tti_tx_queue_if #(.DataWidth(DataWidth), .ThldWidth(ThldWidth)) bus ();

    tti_tx_queue #(
        .Depth(Depth),
        .DataWidth(DataWidth),
        .ThldWidth(ThldWidth)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .q     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        bus.req_i        = 1'b0;
        bus.data_i       = '0;
        bus.ready_thld_i = '0;
        bus.reg_rst_i    = 1'b0;
        bus.ready_i      = 1'b0;
        rst_n            = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        chk("rst_ack",       32'(bus.ack_o), 32'd0);
        chk("rst_valid",     32'(bus.valid_o), 32'd0);
        chk("rst_full",      32'(bus.full_o), 32'd0);
        chk("rst_empty",     32'(bus.empty_o), 32'd1);
        chk("rst_thld",      32'(bus.thld_o), 32'd1);
        chk("rst_rthld",     32'(bus.ready_thld_o), 32'd0);
        chk("rst_data",      bus.data_o, 32'd0);
        chk("rst_we",        32'(bus.reg_rst_we_o), 32'd0);
        chk("rst_wdata",     32'(bus.reg_rst_data_o), 32'd0);
        chk("rst_overflow",  32'(bus.overflow_o), 32'd0);
        #11 rst_n = 1'b1;
        tick();

        // Three writes drained as they arrive.
        bus.ready_i = 1'b1;
        bus.req_i = 1'b1; bus.data_i = 32'hA1; tick();
        chk("a1_ack", 32'(bus.ack_o), 32'd1);
        chk("a1_data", bus.data_o, 32'hA1);
        bus.data_i = 32'hA2; tick();
        chk("a2_ack", 32'(bus.ack_o), 32'd1);
        chk("a2_data", bus.data_o, 32'hA2);
        bus.data_i = 32'hA3; tick();
        chk("a3_ack", 32'(bus.ack_o), 32'd1);
        chk("a3_data", bus.data_o, 32'hA3);
        bus.req_i = 1'b0; tick();
        chk("a_ack_end", 32'(bus.ack_o), 32'd0);
        chk("a_empty", 32'(bus.empty_o), 32'd1);
        bus.ready_i = 1'b0;

        // Soft reset with ten entries queued.
        bus.req_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.data_i = 32'h400 + 32'(i);
            tick();
        end
        bus.req_i = 1'b0;
        chk("sr_notempty", 32'(bus.empty_o), 32'd0);
        chk("sr_head", bus.data_o, 32'h400);
        bus.reg_rst_i = 1'b1; tick();
        chk("sr_we_idle", 32'(bus.reg_rst_we_o), 32'd0);
        chk("sr_valid_pre", 32'(bus.valid_o), 32'd1);
        tick();
        chk("sr_empty", 32'(bus.empty_o), 32'd1);
        chk("sr_we_clear", 32'(bus.reg_rst_we_o), 32'd1);
        chk("sr_wdata", 32'(bus.reg_rst_data_o), 32'd0);
        tick();
        chk("sr_we_wait", 32'(bus.reg_rst_we_o), 32'd0);
        bus.req_i = 1'b1; bus.data_i = 32'hDEAD; tick();
        bus.req_i = 1'b0;
        chk("sr_wait_ack", 32'(bus.ack_o), 32'd1);
        chk("sr_wait_empty", 32'(bus.empty_o), 32'd1);
        chk("sr_we_once", 32'(bus.reg_rst_we_o), 32'd0);
        bus.reg_rst_i = 1'b0; tick();
        bus.req_i = 1'b1; bus.data_i = 32'hB0; tick();
        bus.req_i = 1'b0;
        chk("sr_new_ack", 32'(bus.ack_o), 32'd1);
        chk("sr_new_data", bus.data_o, 32'hB0);
        bus.ready_i = 1'b1; tick();
        bus.ready_i = 1'b0;
        chk("sr_drained", 32'(bus.empty_o), 32'd1);

        // Fill to Depth, then a 65th write waits for space.
        bus.req_i = 1'b1;
        for (int i = 0; i < Depth; i++) begin
            bus.data_i = 32'h100 + 32'(i);
            tick();
        end
        chk("fill_ack", 32'(bus.ack_o), 32'd1);
        chk("fill_full", 32'(bus.full_o), 32'd1);
        chk("fill_head", bus.data_o, 32'h100);
        bus.data_i = 32'h1FF; tick();
        bus.req_i = 1'b0;
        chk("pend_noack", 32'(bus.ack_o), 32'd0);
        tick();
        chk("pend_noack2", 32'(bus.ack_o), 32'd0);
        chk("pend_full", 32'(bus.full_o), 32'd1);
        bus.ready_i = 1'b1; tick();
        bus.ready_i = 1'b0;
        chk("pend_ack", 32'(bus.ack_o), 32'd1);
        chk("pend_count64", 32'(bus.full_o), 32'd1);
        chk("pend_head", bus.data_o, 32'h101);
        tick();
        chk("pend_ack_once", 32'(bus.ack_o), 32'd0);

        // Threshold clamp and free-space compare.
        bus.ready_thld_i = 8'd200; tick();
        chk("thld_clamp", 32'(bus.ready_thld_o), 32'd63);
        bus.ready_thld_i = 8'd4; tick();
        chk("thld_pass", 32'(bus.ready_thld_o), 32'd4);
        tick();
        chk("thld_full", 32'(bus.thld_o), 32'd0);
        bus.ready_i = 1'b1;
        repeat (3) tick();
        bus.ready_i = 1'b0;
        tick(); tick();
        chk("thld_61", 32'(bus.thld_o), 32'd0);
        chk("thld_head", bus.data_o, 32'h104);
        bus.ready_i = 1'b1; tick();
        bus.ready_i = 1'b0;
        tick();
        chk("thld_60", 32'(bus.thld_o), 32'd1);

        // Full again, zero threshold behaves as one.
        bus.req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.data_i = 32'h300 + 32'(i);
            tick();
        end
        bus.req_i = 1'b0;
        chk("ff_full", 32'(bus.full_o), 32'd1);
        bus.ready_thld_i = 8'd0; tick(); tick();
        chk("thld0_rthld", 32'(bus.ready_thld_o), 32'd0);
        chk("thld0_flag", 32'(bus.thld_o), 32'd0);

        // Pending write, second request, then soft reset discards it.
        bus.req_i = 1'b1; bus.data_i = 32'h2AA; tick();
        bus.req_i = 1'b0;
        chk("ov_pend_noack", 32'(bus.ack_o), 32'd0);
        chk("ov_pre", 32'(bus.overflow_o), 32'd0);
        bus.req_i = 1'b1; bus.data_i = 32'h2BB; tick();
        bus.req_i = 1'b0;
        chk("ov_noack", 32'(bus.ack_o), 32'd0);
        chk("ov_set", 32'(bus.overflow_o), 32'(OVF_EXP));
        tick();
        chk("ov_sticky", 32'(bus.overflow_o), 32'(OVF_EXP));
        bus.reg_rst_i = 1'b1; tick();
        chk("fl_noack", 32'(bus.ack_o), 32'd0);
        chk("fl_ov_held", 32'(bus.overflow_o), 32'(OVF_EXP));
        tick();
        chk("fl_ack", 32'(bus.ack_o), 32'd1);
        chk("fl_empty", 32'(bus.empty_o), 32'd1);
        chk("fl_notfull", 32'(bus.full_o), 32'd0);
        chk("fl_ov_clear", 32'(bus.overflow_o), 32'd0);
        bus.reg_rst_i = 1'b0;
        tick(); tick();
        bus.req_i = 1'b1; bus.data_i = 32'hC3; tick();
        bus.req_i = 1'b0;
        chk("end_ack", 32'(bus.ack_o), 32'd1);
        chk("end_data", bus.data_o, 32'hC3);
        chk("end_valid", 32'(bus.valid_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tti_tx_queue.md
TTI_TX_QUEUE -- requirements
Module: tti_tx_queue

Interface
REQ-001 SHALL have parameter Depth, default 64, queue depth in entries (power of two, >=4).
REQ-002 SHALL have parameter DataWidth, default 32, entry width.
REQ-003 SHALL have parameter ThldWidth, default 8, threshold field width.
REQ-004 SHALL have port clk_i  input  1  clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_i  input  1  CSR write request, one-cycle pulse.
REQ-007 SHALL have port data_i  input  DataWidth  CSR write data, valid with req_i.
REQ-008 SHALL have port ack_o  output  1  write acknowledge, one-cycle pulse.
REQ-009 SHALL have port ready_thld_i  input  ThldWidth  software ready threshold.
REQ-010 SHALL have port ready_thld_o  output  ThldWidth  clamped threshold returned to CSR.
REQ-011 SHALL have port reg_rst_i  input  1  soft-reset request level from CSR.
REQ-012 SHALL have port reg_rst_we_o  output  1  CSR write-enable to self-clear the soft-reset bit.
REQ-013 SHALL have port reg_rst_data_o  output  1  CSR value for that write, constant 0.
REQ-014 SHALL have port valid_o  output  1  head entry available to the controller.
REQ-015 SHALL have port ready_i  input  1  controller pops head when valid_o and ready_i.
REQ-016 SHALL have port data_o  output  DataWidth  head entry.
REQ-017 SHALL have port full_o  output  1  count equals Depth.
REQ-018 SHALL have port empty_o  output  1  count equals 0.
REQ-019 SHALL have port thld_o  output  1  free entries >= effective threshold.
REQ-020 SHALL have port overflow_o  output  1  sticky overflow status.

Function
REQ-021 SHALL keep count of width $clog2(Depth+1), with wrapping read/write pointers of width $clog2(Depth).
REQ-022 SHALL, on req_i while not full, store data_i and pulse ack_o the following cycle.
REQ-023 SHALL, on req_i while full, hold the write pending, store it on the first cycle with free space, then pulse ack_o the next cycle.
REQ-024 SHALL accept at most one pending write and ignore req_i while one is pending.
REQ-025 SHALL accept a write when full if a pop occurs the same cycle, leaving count unchanged.
REQ-026 SHALL drive valid_o = !empty_o and data_o = entry at the read pointer, with a pop when valid_o && ready_i.
REQ-027 SHALL make a written entry visible on valid_o one cycle after it is stored.
REQ-028 SHALL register ready_thld_o as min(ready_thld_i, Depth-1), one-cycle latency.
REQ-029 SHALL treat an effective threshold of 0 as 1.
REQ-030 SHALL drive thld_o as registered (Depth - count) >= effective threshold.
REQ-031 SHALL implement a soft-reset FSM with states IDLE, FLUSH, CLEAR and WAIT.
REQ-032 SHALL move from IDLE to FLUSH when reg_rst_i = 1.
REQ-033 SHALL, in FLUSH (one cycle), zero pointers and count, and discard any pending write while still pulsing ack_o for it.
REQ-034 SHALL pulse reg_rst_we_o = 1 for one cycle in CLEAR, with reg_rst_data_o = 0.
REQ-035 SHALL stay in WAIT until reg_rst_i = 0, then return to IDLE.
REQ-036 SHALL, from FLUSH until IDLE, block pops and ack new writes without storing them.

Reset
REQ-037 SHALL, on rst_ni low, asynchronously set: pointers, count and FSM to 0/IDLE; ack_o, reg_rst_we_o, reg_rst_data_o, valid_o, full_o and overflow_o to 0; empty_o and thld_o to 1; ready_thld_o to 0; data_o to 0.
REQ-038 SHALL NOT reset storage contents; data_o is masked to 0 while empty.

Configuration
REQ-039 SHALL implement overflow status only when I3C_TTI_QUEUE_OVERFLOW_EN is defined.
REQ-040 SHALL, when I3C_TTI_QUEUE_OVERFLOW_EN is defined, set overflow_o when req_i arrives while a write is pending, and clear it only on soft-reset FLUSH or rst_ni.
REQ-041 SHALL, when I3C_TTI_QUEUE_OVERFLOW_EN is undefined, tie overflow_o to 0 and include no overflow logic.

Verification
REQ-042 Bench SHALL cover: 3 writes 0xA1, 0xA2, 0xA3 with ready_i = 1 -> ack_o one cycle after each req_i, and data_o shows A1, A2, A3 in order.
REQ-043 Bench SHALL cover: Depth = 64, 64 writes with ready_i = 0, then a 65th write -> full_o = 1 and no ack_o; after one pop, ack_o the cycle after the 65th entry is stored and count = 64.
REQ-044 Bench SHALL cover: ready_thld_i = 200 with Depth = 64 -> ready_thld_o = 63 next cycle; with ready_thld_i = 4 and count = 61 -> thld_o = 0, and after one pop thld_o = 1.
REQ-045 Bench SHALL cover: 10 entries queued, reg_rst_i = 1 -> empty_o = 1 after FLUSH, reg_rst_we_o pulses once with data 0; reg_rst_i = 0 -> IDLE and a new write is accepted.
REQ-046 Bench SHALL cover: queue full with a pending write, soft reset asserted -> ack_o for the pending write, count = 0, and (macro defined) overflow_o = 0.
REQ-047 Bench SHALL cover: with the macro defined, a second req_i while a write is pending -> overflow_o = 1 and stays set until FLUSH; with the macro undefined, overflow_o = 0 throughout.
